// File: rtl/cart_mem_responder.sv
// ============================================================================
// cart_mem_responder: bridges cartridge ROM/BSRAM strobes onto a shared
// 16-bit req/ack memory port with tag caching and a 1-deep write buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cart_mem_responder #(
    parameter logic [24:0] BSRAM_BASE = 25'h1F00000,
    parameter logic [24:0] ROM_BASE   = 25'h0000000
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic [23:0] rom_addr,
    input  logic        rom_ce_n,
    input  logic        rom_oe_n,
    input  logic        rom_word,
    output logic [15:0] rom_q,
    input  logic [19:0] bsram_addr,
    input  logic [7:0]  bsram_d,
    output logic [7:0]  bsram_q,
    input  logic        bsram_ce_n,
    input  logic        bsram_oe_n,
    input  logic        bsram_we_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [24:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        wr_overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROM_RD = 2'd1,
        S_RAM_RD = 2'd2,
        S_RAM_WR = 2'd3
    } state_t;

    state_t      state_q;
    logic [22:0] rom_tag_q;
    logic        rom_tag_v_q;
    logic [22:0] rom_pend_q;
    logic [15:0] rom_data_q;
    logic [19:0] ram_tag_q;
    logic        ram_tag_v_q;
    logic [19:0] ram_pend_q;
    logic        ram_stale_q;
    logic        wbuf_full_q;
    logic        wbuf_redirty_q;
    logic [19:0] wbuf_addr_q;
    logic [7:0]  wbuf_d_q;
    logic        we_n_q;

    logic rom_need;
    logic ram_need;
    logic capture;
    logic wr_done;
    logic [7:0] rom_byte;

    assign rom_need = ~rom_ce_n & ~rom_oe_n &
                      (~rom_tag_v_q | (rom_addr[23:1] != rom_tag_q));
    assign ram_need = ~bsram_ce_n & ~bsram_oe_n & bsram_we_n &
                      (~ram_tag_v_q | (bsram_addr != ram_tag_q));
    assign capture  = we_n_q & ~bsram_we_n & ~bsram_ce_n;
    assign wr_done  = (state_q == S_RAM_WR) & mem_ack;

    assign rom_byte = rom_addr[0] ? rom_data_q[15:8] : rom_data_q[7:0];
    assign rom_q    = rom_word ? rom_data_q : {rom_byte, rom_byte};
    assign busy     = (state_q != S_IDLE) | wbuf_full_q | rom_need | ram_need;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rom_tag_q      <= '0;
            rom_tag_v_q    <= 1'b0;
            rom_pend_q     <= '0;
            rom_data_q     <= '0;
            ram_tag_q      <= '0;
            ram_tag_v_q    <= 1'b0;
            ram_pend_q     <= '0;
            ram_stale_q    <= 1'b0;
            wbuf_full_q    <= 1'b0;
            wbuf_redirty_q <= 1'b0;
            wbuf_addr_q    <= '0;
            wbuf_d_q       <= '0;
            we_n_q         <= 1'b1;
            bsram_q        <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= '0;
            mem_wdata      <= '0;
            wr_overflow    <= 1'b0;
        end else begin
            wr_overflow <= 1'b0;
            we_n_q      <= bsram_we_n;

            case (state_q)
                S_IDLE: begin
                    if (wbuf_full_q) begin
                        state_q        <= S_RAM_WR;
                        mem_req        <= 1'b1;
                        mem_we         <= 1'b1;
                        mem_addr       <= BSRAM_BASE + {5'd0, wbuf_addr_q};
                        mem_be         <= wbuf_addr_q[0] ? 2'b10 : 2'b01;
                        mem_wdata      <= {wbuf_d_q, wbuf_d_q};
                        wbuf_redirty_q <= 1'b0;
                    end else if (rom_need) begin
                        state_q    <= S_ROM_RD;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= ROM_BASE + {1'b0, rom_addr[23:1], 1'b0};
                        mem_be     <= 2'b11;
                        mem_wdata  <= '0;
                        rom_pend_q <= rom_addr[23:1];
                    end else if (ram_need) begin
                        state_q     <= S_RAM_RD;
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= BSRAM_BASE + {5'd0, bsram_addr};
                        mem_be      <= 2'b11;
                        mem_wdata   <= '0;
                        ram_pend_q  <= bsram_addr;
                        ram_stale_q <= 1'b0;
                    end
                end
                S_ROM_RD: begin
                    if (mem_ack) begin
                        state_q     <= S_IDLE;
                        mem_req     <= 1'b0;
                        rom_data_q  <= mem_rdata;
                        rom_tag_q   <= rom_pend_q;
                        rom_tag_v_q <= 1'b1;
                    end
                end
                S_RAM_RD: begin
                    if (mem_ack) begin
                        state_q <= S_IDLE;
                        mem_req <= 1'b0;
                        if (!ram_stale_q) begin
                            bsram_q     <= ram_pend_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
                            ram_tag_q   <= ram_pend_q;
                            ram_tag_v_q <= 1'b1;
                        end
                    end
                end
                S_RAM_WR: begin
                    if (mem_ack) begin
                        state_q        <= S_IDLE;
                        mem_req        <= 1'b0;
                        mem_we         <= 1'b0;
                        wbuf_full_q    <= wbuf_redirty_q;
                        wbuf_redirty_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Placed after the FSM so a same-cycle capture overrides any read
            // completion or buffer release for the data and tag it touches.
            if (capture) begin
                wbuf_full_q <= 1'b1;
                wbuf_addr_q <= bsram_addr;
                wbuf_d_q    <= bsram_d;
                bsram_q     <= bsram_d;
                ram_tag_q   <= bsram_addr;
                ram_tag_v_q <= 1'b1;
                if (wbuf_full_q && !(wr_done && !wbuf_redirty_q))
                    wr_overflow <= 1'b1;
                if ((state_q == S_RAM_WR) && !mem_ack)
                    wbuf_redirty_q <= 1'b1;
                if ((state_q == S_RAM_RD) && (bsram_addr == ram_pend_q))
                    ram_stale_q <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cart_mem_responder.sv
// ============================================================================
// tb_cart_mem_responder: directed self-checking bench for cart_mem_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cart_mem_responder;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] rom_addr = '0;
    logic        rom_ce_n = 1'b1;
    logic        rom_oe_n = 1'b1;
    logic        rom_word = 1'b1;
    logic [15:0] rom_q;
    logic [19:0] bsram_addr = '0;
    logic [7:0]  bsram_d = '0;
    logic [7:0]  bsram_q;
    logic        bsram_ce_n = 1'b1;
    logic        bsram_oe_n = 1'b1;
    logic        bsram_we_n = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        wr_overflow;

    int total = 0;
    int bad   = 0;

    cart_mem_responder dut (
        .mclk(mclk), .rst_n(rst_n),
        .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
        .rom_word(rom_word), .rom_q(rom_q),
        .bsram_addr(bsram_addr), .bsram_d(bsram_d), .bsram_q(bsram_q),
        .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .wr_overflow(wr_overflow)
    );

    always #5 mclk = ~mclk;

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL %s: mem_req=%b required 1 within 20 cycles", name, mem_req);
        end
    endtask

    task automatic do_ack(input logic [15:0] d);
        step();
        step();
        mem_ack   = 1'b1;
        mem_rdata = d;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
        total++; if (mem_addr !== 25'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        total++; if (rom_q !== 16'h0 || bsram_q !== 8'h0) begin bad++; $display("FAIL rst_q: rom_q=%h bsram_q=%h want 0", rom_q, bsram_q); end
        total++; if (busy !== 1'b0 || wr_overflow !== 1'b0) begin bad++; $display("FAIL rst_busy: busy=%b ovf=%b want 0", busy, wr_overflow); end
        rst_n = 1'b1;
        step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_idle_req: got %b want 0", mem_req); end
    endtask

    task automatic test_rom_word();
        rom_addr = 24'h000124; rom_word = 1'b1; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL romw_busy: got %b want 1", busy); end
        step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL romw_latency: mem_req=%b want 1", mem_req); end
        wait_req("romw_req");
        total++; if (mem_addr !== 25'h0000124 || mem_we !== 1'b0) begin bad++; $display("FAIL romw_addr: addr=%h we=%b want 0000124/0", mem_addr, mem_we); end
        do_ack(16'hBEEF);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL romw_drop: mem_req=%b want 0", mem_req); end
        total++; if (rom_q !== 16'hBEEF) begin bad++; $display("FAIL romw_data: got %h want BEEF", rom_q); end
        rom_addr = 24'h000125;
        step(); step();
        total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL romw_hit: req=%b busy=%b want 0/0", mem_req, busy); end
    endtask

    task automatic test_rom_byte();
        rom_word = 1'b0;
        #1;
        total++; if (rom_q !== 16'hBEBE) begin bad++; $display("FAIL romb_hi: got %h want BEBE", rom_q); end
        rom_addr = 24'h000124;
        #1;
        total++; if (rom_q !== 16'hEFEF) begin bad++; $display("FAIL romb_lo: got %h want EFEF", rom_q); end
        step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL romb_noreq: got %b want 0", mem_req); end
        rom_addr = 24'h000126;
        wait_req("romb_req");
        total++; if (mem_addr !== 25'h0000126) begin bad++; $display("FAIL romb_addr: got %h want 0000126", mem_addr); end
        do_ack(16'h1234);
        total++; if (rom_q !== 16'h3434) begin bad++; $display("FAIL romb_data: got %h want 3434", rom_q); end
        rom_ce_n = 1'b1; rom_oe_n = 1'b1; rom_word = 1'b1;
        step();
    endtask

    task automatic test_bsram_write();
        bsram_addr = 20'h00003; bsram_d = 8'h5A; bsram_ce_n = 1'b0; bsram_we_n = 1'b1;
        step();
        bsram_we_n = 1'b0;
        step();
        total++; if (bsram_q !== 8'h5A || busy !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL wr_capture: q=%h busy=%b req=%b want 5A/1/0", bsram_q, busy, mem_req); end
        step();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL wr_req: req=%b we=%b want 1/1", mem_req, mem_we); end
        total++; if (mem_addr !== 25'h1F00003 || mem_be !== 2'b10 || mem_wdata !== 16'h5A5A) begin bad++; $display("FAIL wr_fields: addr=%h be=%b wdata=%h want 1F00003/10/5A5A", mem_addr, mem_be, mem_wdata); end
        bsram_we_n = 1'b1;
        do_ack(16'h0000);
        total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL wr_done: req=%b we=%b want 0/0", mem_req, mem_we); end
        step(); step(); step();
        total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wr_once: req=%b busy=%b want 0/0", mem_req, busy); end
        bsram_oe_n = 1'b0;
        step(); step();
        total++; if (mem_req !== 1'b0 || bsram_q !== 8'h5A) begin bad++; $display("FAIL rd_hit: req=%b q=%h want 0/5A", mem_req, bsram_q); end
        bsram_addr = 20'h00004;
        wait_req("rd_miss_req");
        total++; if (mem_addr !== 25'h1F00004 || mem_we !== 1'b0) begin bad++; $display("FAIL rd_addr: addr=%h we=%b want 1F00004/0", mem_addr, mem_we); end
        do_ack(16'h6677);
        total++; if (bsram_q !== 8'h77) begin bad++; $display("FAIL rd_data: got %h want 77", bsram_q); end
        bsram_oe_n = 1'b1; bsram_ce_n = 1'b1;
        step();
    endtask

    task automatic test_overflow();
        rom_addr = 24'h000300; rom_word = 1'b1; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        wait_req("ovf_rom_req");
        bsram_ce_n = 1'b0; bsram_addr = 20'h00008; bsram_d = 8'h11; bsram_we_n = 1'b0;
        step();
        total++; if (wr_overflow !== 1'b0) begin bad++; $display("FAIL ovf_first: got %b want 0", wr_overflow); end
        bsram_we_n = 1'b1;
        step();
        bsram_d = 8'h22; bsram_we_n = 1'b0;
        step();
        total++; if (wr_overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b want 1", wr_overflow); end
        bsram_we_n = 1'b1;
        step();
        total++; if (wr_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", wr_overflow); end
        total++; if (mem_we !== 1'b0 || mem_addr !== 25'h0000300) begin bad++; $display("FAIL ovf_rom_hold: we=%b addr=%h want 0/0000300", mem_we, mem_addr); end
        do_ack(16'hCAFE);
        total++; if (rom_q !== 16'hCAFE) begin bad++; $display("FAIL ovf_rom_data: got %h want CAFE", rom_q); end
        step();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h2222) begin bad++; $display("FAIL ovf_wr: req=%b we=%b wdata=%h want 1/1/2222", mem_req, mem_we, mem_wdata); end
        total++; if (mem_addr !== 25'h1F00008 || mem_be !== 2'b01) begin bad++; $display("FAIL ovf_wr_addr: addr=%h be=%b want 1F00008/01", mem_addr, mem_be); end
        do_ack(16'h0000);
        step(); step();
        total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ovf_single: req=%b busy=%b want 0/0", mem_req, busy); end
        rom_ce_n = 1'b1; rom_oe_n = 1'b1; bsram_ce_n = 1'b1;
        step();
    endtask

    task automatic test_reset_midop();
        rom_addr = 24'h000500; rom_word = 1'b1; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        wait_req("rmid_req");
        rom_ce_n = 1'b1; rom_oe_n = 1'b1;
        rst_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || mem_addr !== 25'h0) begin bad++; $display("FAIL rmid_drop: req=%b addr=%h want 0/0", mem_req, mem_addr); end
        total++; if (rom_q !== 16'h0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_out: rom_q=%h busy=%b want 0/0", rom_q, busy); end
        step();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        step();
        total++; if (mem_req !== 1'b0 || rom_q !== 16'h0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_ack_ignored: req=%b rom_q=%h busy=%b want 0/0000/0", mem_req, rom_q, busy); end
    endtask

    task automatic test_addr_change();
        rom_addr = 24'h000200; rom_word = 1'b1; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        wait_req("chg_req1");
        total++; if (mem_addr !== 25'h0000200) begin bad++; $display("FAIL chg_addr1: got %h want 0000200", mem_addr); end
        rom_addr = 24'h000400;
        do_ack(16'hAAAA);
        total++; if (rom_q !== 16'hAAAA || mem_req !== 1'b0) begin bad++; $display("FAIL chg_first: rom_q=%h req=%b want AAAA/0", rom_q, mem_req); end
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 25'h0000400) begin bad++; $display("FAIL chg_refetch: req=%b addr=%h want 1/0000400", mem_req, mem_addr); end
        do_ack(16'h5555);
        total++; if (rom_q !== 16'h5555) begin bad++; $display("FAIL chg_second: got %h want 5555", rom_q); end
        rom_ce_n = 1'b1; rom_oe_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_rom_word();
        test_rom_byte();
        test_bsram_write();
        test_overflow();
        test_reset_midop();
        test_addr_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
